// File: rtl/pilha_param.sv
// Parametrised LIFO stack with occupancy count, top-of-stack peek and replace-top.
// Optional sticky overflow/underflow flags are enabled by defining PILHA_ERR_EN.
module pilha_param #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  input  logic             err_clr,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             ovf,
  output logic             unf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    sp_q, sp_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [AW-1:0]    top_idx, wr_idx;
  logic             ovf_ev, unf_ev;

  assign empty   = (sp_q == '0);
  assign full    = (sp_q == CW'(DEPTH));
  assign count   = sp_q;
  assign dout    = dout_q;
  // Index arithmetic is only used when the matching empty/full guard is clear.
  assign top_idx = AW'(sp_q - CW'(1));
  assign wr_idx  = AW'(sp_q);
  assign top     = empty ? '0 : mem_q[top_idx];

  always_comb begin
    sp_d   = sp_q;
    dout_d = dout_q;
    mem_d  = mem_q;
    ovf_ev = 1'b0;
    unf_ev = 1'b0;
    unique case ({push, pop})
      2'b10: begin
        if (!full) begin
          mem_d[wr_idx] = din;
          sp_d          = sp_q + CW'(1);
        end else begin
          ovf_ev = 1'b1;
        end
      end
      2'b01: begin
        if (!empty) begin
          dout_d = mem_q[top_idx];
          sp_d   = sp_q - CW'(1);
        end else begin
          unf_ev = 1'b1;
        end
      end
      2'b11: begin
        if (!empty) begin
          dout_d         = mem_q[top_idx];
          mem_d[top_idx] = din;
        end else begin
          // Push half still lands; only the pop half is rejected.
          mem_d[0] = din;
          sp_d     = CW'(1);
          unf_ev   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q   <= '0;
      dout_q <= '0;
    end else begin
      sp_q   <= sp_d;
      dout_q <= dout_d;
    end
  end

  // Storage needs no reset: sp bounds what is ever read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef PILHA_ERR_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  always_comb begin
    ovf_d = ovf_ev ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
    unf_d = unf_ev ? 1'b1 : (err_clr ? 1'b0 : unf_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ovf = ovf_q;
  assign unf = unf_q;
`else
  logic unused_err;
  assign unused_err = ^{err_clr, ovf_ev, unf_ev};
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif

endmodule

// File: tb/tb_pilha_param.sv
// Scoreboard bench for pilha_param (WIDTH=8, DEPTH=4); flag expectations follow PILHA_ERR_EN.
module tb_pilha_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef PILHA_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             push = 1'b0, pop = 1'b0, err_clr = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] dout, top;
  logic             empty, full, ovf, unf;
  logic [CW-1:0]    count;

  pilha_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din), .err_clr(err_clr),
    .dout(dout), .top(top), .empty(empty), .full(full), .count(count),
    .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] stk [$];
  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] m_dout = '0;
  bit               m_ovf = 1'b0, m_unf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input bit p, input bit q, input logic [WIDTH-1:0] d,
                      input bit clr = 1'b0, input bit r = 1'b0);
    bit ov_ev = 1'b0, un_ev = 1'b0;
    @(negedge clk);
    push = p; pop = q; din = d; err_clr = clr; rst = r;
    if (r) begin
      stk.delete(); exp_q.delete();
      m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      if (p && !q) begin
        if (stk.size() < DEPTH) stk.push_back(d); else ov_ev = 1'b1;
      end else if (!p && q) begin
        if (stk.size() > 0) exp_q.push_back(stk.pop_back()); else un_ev = 1'b1;
      end else if (p && q) begin
        if (stk.size() > 0) begin
          exp_q.push_back(stk[$]);
          stk[$] = d;
        end else begin
          stk.push_back(d);
          un_ev = 1'b1;
        end
      end
      if (ERR) begin
        m_ovf = ov_ev | (m_ovf & !clr);
        m_unf = un_ev | (m_unf & !clr);
      end
    end
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; err_clr = 1'b0; rst = 1'b0;
    if (exp_q.size() > 0) begin
      m_dout = exp_q.pop_front();
      chk("dout_pop", dout, m_dout);
    end else begin
      chk("dout_hold", dout, m_dout);
    end
    chk("count", count, stk.size());
    chk("empty", empty, stk.size() == 0);
    chk("full", full, stk.size() == DEPTH);
    chk("top", top, (stk.size() > 0) ? stk[$] : 8'h00);
    chk("ovf", ovf, m_ovf);
    chk("unf", unf, m_unf);
  endtask

  initial begin
    // 1. reset sequence
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0, 1);
    step(0, 0, 8'h00);
    chk("t1_count", count, 0);
    chk("t1_empty", empty, 1);
    chk("t1_dout", dout, 8'h00);
    chk("t1_top", top, 8'h00);

    // 2. fill and overflow
    step(1, 0, 8'h11); step(1, 0, 8'h22); step(1, 0, 8'h33); step(1, 0, 8'h44);
    step(1, 0, 8'h55);
    chk("t2_full", full, 1);
    chk("t2_count", count, 4);
    chk("t2_top", top, 8'h44);
    chk("t2_ovf", ovf, ERR);
    step(0, 0, 8'h00, 1);
    chk("t2_ovf_clr", ovf, 0);

    // 3. drain and underflow
    step(0, 1, 8'h00); chk("t3_dout0", dout, 8'h44);
    step(0, 1, 8'h00); chk("t3_dout1", dout, 8'h33);
    step(0, 1, 8'h00); chk("t3_dout2", dout, 8'h22);
    step(0, 1, 8'h00); chk("t3_dout3", dout, 8'h11);
    chk("t3_empty", empty, 1);
    step(0, 1, 8'h00);
    chk("t3_dout_hold", dout, 8'h11);
    chk("t3_unf", unf, ERR);
    step(0, 0, 8'h00, 1);

    // 4. replace-top
    step(1, 0, 8'hAA); step(1, 0, 8'hBB);
    step(1, 1, 8'hCC);
    chk("t4_dout", dout, 8'hBB);
    chk("t4_top", top, 8'hCC);
    chk("t4_count", count, 2);
    step(1, 0, 8'hDD); step(1, 0, 8'hEE);
    step(1, 1, 8'hF0);
    chk("t4_full_count", count, 4);
    chk("t4_full_dout", dout, 8'hEE);
    chk("t4_full_ovf", ovf, 0);

    // 5. push+pop on empty
    step(0, 0, 8'h00, 0, 1);
    step(1, 1, 8'h77);
    chk("t5_count", count, 1);
    chk("t5_top", top, 8'h77);
    chk("t5_dout", dout, 8'h00);
    chk("t5_unf", unf, ERR);

    // 6. reset mid-operation, reset beats a simultaneous push
    step(1, 0, 8'h01); step(1, 0, 8'h02); step(1, 0, 8'h03);
    step(1, 0, 8'h04, 0, 1);
    chk("t6_count", count, 0);
    chk("t6_empty", empty, 1);
    chk("t6_ovf", ovf, 0);
    chk("t6_unf", unf, 0);

    // random mix, including err_clr colliding with events
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
